board_scanout: RTL and testbench
================================

BOARD_SCANOUT -- requirements
Module: board_scanout

Interface
REQ-001 SHALL have parameter TOP_FIRST, default 1: 1 = rows scanned y=19 down to y=0; 0 = rows scanned y=0 up to y=19.
REQ-002 SHALL have parameter GAP_CYCLES, default 2: number of idle cycles enforced after each frame, legal range 0..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to scan out one frame.
REQ-006 SHALL have port frame_in, input, game_state_t (game_state_pkg): the composited board from blit_piece out_state; screen[x][y], x 0..9, y 0..19, 1 = filled.
REQ-007 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-008 SHALL have port px_valid, output, 1 bit: pixel beat valid.
REQ-009 SHALL have port px_ready, input, 1 bit: downstream accepts the beat.
REQ-010 SHALL have port px_data, output, 1 bit: cell value of the current beat.
REQ-011 SHALL have port px_x, output, 4 bits: column of the current beat, 0..9.
REQ-012 SHALL have port px_y, output, 5 bits: row of the current beat, 0..19.
REQ-013 SHALL have port px_last, output, 1 bit: high only on the 200th beat of a frame.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse after a frame completes.
REQ-015 SHALL have port frame_count, output, 8 bits: completed frames since reset, wrapping 255 -> 0.

Function
REQ-016 SHALL implement the states IDLE, SEND and GAP.
REQ-017 SHALL, in IDLE with start=1, copy frame_in into an internal snapshot register and enter SEND on the same edge.
REQ-018 SHALL assert px_valid in the first cycle of SEND, so the first beat appears one cycle after start is sampled.
REQ-019 SHALL drive every beat from the snapshot only; frame_in changes during SEND or GAP SHALL NOT affect output.
REQ-020 SHALL complete a transfer only on a cycle where px_valid=1 and px_ready=1.
REQ-021 SHALL hold px_data, px_x, px_y, px_last and px_valid stable while px_valid=1 and px_ready=0.
REQ-022 SHALL order beats row by row, with x running 0..9 within each row and row order set by TOP_FIRST; a frame is exactly 200 beats.
REQ-023 SHALL support back-to-back beats, one transfer per cycle while px_ready is held at 1.
REQ-024 SHALL, on the transfer of the px_last beat, drop px_valid on the next cycle, pulse frame_done for exactly that one cycle, and increment frame_count in that same cycle.
REQ-025 SHALL, after the last beat, enter GAP for exactly GAP_CYCLES cycles and then go to IDLE, or go directly to IDLE when GAP_CYCLES=0.
REQ-026 SHALL ignore start in SEND and GAP: requests are not queued and the snapshot is not reloaded.
REQ-027 SHALL accept start in the first IDLE cycle after GAP, so the minimum frame period is 200+GAP_CYCLES+1 cycles.
REQ-028 SHALL hold px_x, px_y, px_data and px_last at 0 whenever px_valid=0.

Reset
REQ-029 SHALL, with reset=1 at a rising edge, enter IDLE and set busy, px_valid, px_data, px_x, px_y, px_last, frame_done and frame_count to 0, and clear the snapshot.
REQ-030 SHALL, when reset occurs mid-frame, abort the frame with no frame_done pulse and no frame_count increment.
REQ-031 SHALL give reset priority over start in the same cycle.

Verification
REQ-032 Frame with bottom row filled, 2x2 block at x=3..4, y=3..4, TOP_FIRST=1, px_ready=1 -> 200 beats in 200 consecutive cycles:
- first beat (x=0, y=19, data 0);
- data=1 exactly at beats (3,4), (4,4), (3,3), (4,3) and all of y=0;
- px_last on (9,0);
- frame_done pulses 1 cycle later and frame_count=1.
REQ-033 px_ready toggled pseudo-randomly at 50% -> the same 200-beat sequence as REQ-032; outputs never change while stalled.
REQ-034 frame_in changed to all-ones at beat 50 -> the output remains the original snapshot.
REQ-035 start held high continuously with GAP_CYCLES=2 -> frames begin every 203 cycles with no start accepted while busy=1.
REQ-036 reset asserted at beat 120 -> the next cycle shows all outputs 0, no frame_done, frame_count unchanged (0); a new start yields a full 200-beat frame.
REQ-037 TOP_FIRST=0 with 256 frames sent -> the first beat is (0,0), and frame_count wraps to 0 after the 256th frame.

Source files
------------

// File: rtl/board_scanout.sv
// Board scan-out: snapshots the composited 10x20 board on start and streams it
// one cell per valid/ready beat, row by row, followed by an idle gap.
package game_state_pkg;
  typedef struct packed {
    logic [9:0][19:0] screen;
  } game_state_t;
endpackage

module board_scanout
  import game_state_pkg::*;
#(
  parameter int TOP_FIRST  = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  game_state_t frame_in,
  output logic        busy,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        px_data,
  output logic [3:0]  px_x,
  output logic [4:0]  px_y,
  output logic        px_last,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  localparam logic [4:0] ROW_FIRST = (TOP_FIRST != 0) ? 5'd19 : 5'd0;
  localparam logic [4:0] ROW_LAST  = (TOP_FIRST != 0) ? 5'd0 : 5'd19;
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  game_state_t snap_q, snap_d;
  logic [3:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [3:0]  gap_q, gap_d;
  logic        done_q, done_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        xfer;
  logic        beat_last;

  assign xfer      = (state_q == S_SEND) && px_ready;
  assign beat_last = (x_q == 4'd9) && (y_q == ROW_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SEND;
      S_SEND:  if (xfer && beat_last) state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (gap_q <= 4'd1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scan position, gap countdown and frame bookkeeping
  always_comb begin
    snap_d = snap_q;
    x_d    = x_q;
    y_d    = y_q;
    gap_d  = gap_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d = frame_in;
          x_d    = 4'd0;
          y_d    = ROW_FIRST;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (x_q == 4'd9) begin
            x_d = 4'd0;
            if (beat_last) begin
              done_d = 1'b1;
              cnt_d  = cnt_q + 8'd1;
              gap_d  = GAP_LOAD;
              y_d    = ROW_FIRST;
            end else begin
              y_d = (TOP_FIRST != 0) ? (y_q - 5'd1) : (y_q + 5'd1);
            end
          end else begin
            x_d = x_q + 4'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_q != 4'd0) gap_d = gap_q - 4'd1;
      end
      default: ;
    endcase
  end

  // A reset mid-frame drops the frame without any completion side effects
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      gap_q  <= '0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      snap_q <= snap_d;
      x_q    <= x_d;
      y_q    <= y_d;
      gap_q  <= gap_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    px_valid = (state_q == S_SEND);
    px_data  = 1'b0;
    px_x     = 4'd0;
    px_y     = 5'd0;
    px_last  = 1'b0;
    if (state_q == S_SEND) begin
      px_data = snap_q.screen[x_q][y_q];
      px_x    = x_q;
      px_y    = y_q;
      px_last = beat_last;
    end
  end

  assign frame_done  = done_q;
  assign frame_count = cnt_q;

endmodule

// File: tb/tb_board_scanout.sv
// Scoreboard bench for board_scanout: instance 0 scans top-first with a 2-cycle
// gap, instance 1 scans bottom-first with no gap.
module tb_board_scanout;
  import game_state_pkg::*;

  typedef struct packed {
    logic       d;
    logic [3:0] x;
    logic [4:0] y;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic       busy;
    logic       valid;
    logic       fd;
    logic [7:0] cnt;
  } stat_t;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] start_w, ready_w;
  game_state_t frame_w [2];
  logic [1:0] busy_w, valid_w, data_w, last_w, fd_w;
  logic [1:0][3:0] x_w;
  logic [1:0][4:0] y_w;
  logic [1:0][7:0] cnt_w;

  always #5 clk = ~clk;

  board_scanout #(.TOP_FIRST(1), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_w[0]), .frame_in(frame_w[0]),
    .busy(busy_w[0]), .px_valid(valid_w[0]), .px_ready(ready_w[0]),
    .px_data(data_w[0]), .px_x(x_w[0]), .px_y(y_w[0]), .px_last(last_w[0]),
    .frame_done(fd_w[0]), .frame_count(cnt_w[0])
  );

  board_scanout #(.TOP_FIRST(0), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_w[1]), .frame_in(frame_w[1]),
    .busy(busy_w[1]), .px_valid(valid_w[1]), .px_ready(ready_w[1]),
    .px_data(data_w[1]), .px_x(x_w[1]), .px_y(y_w[1]), .px_last(last_w[1]),
    .frame_done(fd_w[1]), .frame_count(cnt_w[1])
  );

  function automatic int tf(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic int gapc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  beat_t bq0[$], bq1[$];
  stat_t sq0[$], sq1[$];
  int total = 0;
  int bad = 0;
  bit final_chk = 1'b0;

  // Expected beat list of a whole frame, from the row/column ordering rules
  task automatic load_frame(input int i, input game_state_t f);
    beat_t b;
    for (int r = 0; r < 20; r++) begin
      int y;
      y = (tf(i) != 0) ? 19 - r : r;
      for (int x = 0; x < 10; x++) begin
        b.d    = f.screen[x][y];
        b.x    = 4'(x);
        b.y    = 5'(y);
        b.last = (r == 19) && (x == 9);
        if (i == 0) bq0.push_back(b); else bq1.push_back(b);
      end
    end
  endtask

  // Predictor: follows the inputs at each edge and queues the expected status
  initial begin
    int m_st[2], m_beats[2], m_gap[2];
    logic m_fd[2];
    logic [7:0] m_cnt[2];
    stat_t s;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_beats[i] = 0; m_gap[i] = 0; m_fd[i] = 1'b0; m_cnt[i] = 8'd0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          m_st[i] = 0; m_fd[i] = 1'b0; m_cnt[i] = 8'd0; m_beats[i] = 0; m_gap[i] = 0;
          if (i == 0) bq0.delete(); else bq1.delete();
        end else begin
          m_fd[i] = 1'b0;
          case (m_st[i])
            0: if (start_w[i]) begin
                 load_frame(i, frame_w[i]);
                 m_st[i] = 1;
                 m_beats[i] = 200;
               end
            1: if (ready_w[i]) begin
                 m_beats[i] = m_beats[i] - 1;
                 if (m_beats[i] == 0) begin
                   m_fd[i] = 1'b1;
                   m_cnt[i] = m_cnt[i] + 8'd1;
                   if (gapc(i) == 0) m_st[i] = 0;
                   else begin m_st[i] = 2; m_gap[i] = gapc(i); end
                 end
               end
            default: if (m_gap[i] <= 1) m_st[i] = 0; else m_gap[i] = m_gap[i] - 1;
          endcase
        end
        s.busy  = (m_st[i] != 0);
        s.valid = (m_st[i] == 1);
        s.fd    = m_fd[i];
        s.cnt   = m_cnt[i];
        if (i == 0) sq0.push_back(s); else sq1.push_back(s);
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%0h want=%0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Monitor: compares status every cycle and pops a beat on every transfer
  initial begin
    bit pv_stall[2];
    beat_t prev[2];
    beat_t cur, e;
    stat_t st;
    bit final_done;
    final_done = 1'b0;
    for (int i = 0; i < 2; i++) begin pv_stall[i] = 1'b0; prev[i] = '0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        cur = {data_w[i], x_w[i], y_w[i], last_w[i]};
        if ((i == 0 && sq0.size() == 0) || (i == 1 && sq1.size() == 0)) begin
          total++; bad++;
          $display("FAIL status_queue inst%0d got=empty want=entry", i);
        end else begin
          st = (i == 0) ? sq0.pop_front() : sq1.pop_front();
          chk("busy", i, 32'(busy_w[i]), 32'(st.busy));
          chk("px_valid", i, 32'(valid_w[i]), 32'(st.valid));
          chk("frame_done", i, 32'(fd_w[i]), 32'(st.fd));
          chk("frame_count", i, 32'(cnt_w[i]), 32'(st.cnt));
        end
        if (!valid_w[i]) chk("idle_zero", i, 32'(cur), 32'd0);
        if (pv_stall[i]) chk("stall_hold", i, 32'({valid_w[i], cur}), 32'({1'b1, prev[i]}));
        if (valid_w[i] && ready_w[i] && !reset) begin
          if ((i == 0 && bq0.size() == 0) || (i == 1 && bq1.size() == 0)) begin
            total++; bad++;
            $display("FAIL extra_beat inst%0d got=%0h want=none", i, cur);
          end else begin
            e = (i == 0) ? bq0.pop_front() : bq1.pop_front();
            chk("beat", i, 32'(cur), 32'(e));
          end
        end
        pv_stall[i] = valid_w[i] && !ready_w[i] && !reset;
        prev[i] = cur;
      end
      if (final_chk && !final_done) begin
        chk("leftover_beats", 0, 32'(bq0.size()), 32'd0);
        chk("leftover_beats", 1, 32'(bq1.size()), 32'd0);
        final_done = 1'b1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic game_state_t rand_frame();
    game_state_t f;
    for (int x = 0; x < 10; x++)
      for (int y = 0; y < 20; y++)
        f.screen[x][y] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  initial begin
    game_state_t f;
    reset = 1'b1;
    start_w = 2'b00;
    ready_w = 2'b11;
    frame_w[0] = '0;
    frame_w[1] = '0;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // Bottom row plus 2x2 block, full-rate, frame_in overwritten mid-frame
    f = '0;
    for (int x = 0; x < 10; x++) f.screen[x][0] = 1'b1;
    f.screen[3][3] = 1'b1; f.screen[4][3] = 1'b1;
    f.screen[3][4] = 1'b1; f.screen[4][4] = 1'b1;
    frame_w[0] = f;
    start_w[0] = 1'b1; cyc(1); start_w[0] = 1'b0;
    cyc(49); frame_w[0] = '1;
    cyc(160);

    // Same board under random backpressure
    frame_w[0] = f;
    start_w[0] = 1'b1; cyc(1); start_w[0] = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      ready_w[0] = 1'($urandom_range(0, 1));
      if (k == 50) frame_w[0] = '1;
      cyc(1);
    end
    ready_w[0] = 1'b1;
    cyc(210);

    // Random board with stalls
    frame_w[0] = rand_frame();
    start_w[0] = 1'b1; cyc(1); start_w[0] = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      ready_w[0] = 1'($urandom_range(0, 1));
      cyc(1);
    end
    ready_w[0] = 1'b1;
    cyc(210);

    // start held high across several frames
    frame_w[0] = rand_frame();
    start_w[0] = 1'b1;
    cyc(3 * 203 + 5);
    start_w[0] = 1'b0;
    cyc(210);

    // Reset mid-frame, with start asserted alongside it
    frame_w[0] = rand_frame();
    start_w[0] = 1'b1; cyc(1); start_w[0] = 1'b0;
    cyc(119);
    reset = 1'b1; start_w[0] = 1'b1;
    cyc(1);
    reset = 1'b0; start_w[0] = 1'b0;
    cyc(2);
    start_w[0] = 1'b1; cyc(1); start_w[0] = 1'b0;
    cyc(210);

    // Bottom-first, no gap: 256 frames to wrap the counter
    frame_w[1] = rand_frame();
    start_w[1] = 1'b1;
    cyc(256 * 201 - 10);
    start_w[1] = 1'b0;
    cyc(250);

    final_chk = 1'b1;
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
